// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4-slot TDM link.
// Locks onto frame_sync, steers accepted samples into slot registers by a
// 2-bit slot counter and publishes the four lanes as one registered word per frame.
// Optional build macro: TDM_DEMUX_STICKY_ERR_EN (err latches until reset).
module tdm_demux4 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in,
    input  logic               in_valid,
    input  logic               frame_sync,
    output logic [4*WIDTH-1:0] out,
    output logic               out_valid,
    output logic [1:0]         slot,
    output logic               locked,
    output logic               err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [1:0]         slot_q, slot_n;
    logic [WIDTH-1:0]   lane0_q, lane0_n;
    logic [WIDTH-1:0]   lane1_q, lane1_n;
    logic [WIDTH-1:0]   lane2_q, lane2_n;
    logic [4*WIDTH-1:0] out_q, out_n;
    logic               out_valid_n, out_valid_q;
    logic               err_n, err_q;
    logic               sync_err;

    // State, slot counter, lanes and outputs; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            lane0_q     <= '0;
            lane1_q     <= '0;
            lane2_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            slot_q      <= slot_n;
            lane0_q     <= lane0_n;
            lane1_q     <= lane1_n;
            lane2_q     <= lane2_n;
            out_q       <= out_n;
            out_valid_q <= out_valid_n;
            err_q       <= err_n;
        end
    end

    // Sync error: frame_sync on an accepted sample while locked and not at slot 0.
    always_comb begin
        sync_err = in_valid && frame_sync && (state_q == LOCKED) && (slot_q != 2'd0);
    end

    // Next-state, lane steering and frame publication.
    always_comb begin
        state_n     = state_q;
        slot_n      = slot_q;
        lane0_n     = lane0_q;
        lane1_n     = lane1_q;
        lane2_n     = lane2_q;
        out_n       = out_q;
        out_valid_n = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        lane0_n = in;
                        slot_n  = 2'd1;
                        state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync_err) begin
                        // Error takes priority over slot-3 completion: restart the frame at lane0.
                        lane0_n = in;
                        slot_n  = 2'd1;
                    end else begin
                        unique case (slot_q)
                            2'd0: begin
                                lane0_n = in;
                                slot_n  = 2'd1;
                            end
                            2'd1: begin
                                lane1_n = in;
                                slot_n  = 2'd2;
                            end
                            2'd2: begin
                                lane2_n = in;
                                slot_n  = 2'd3;
                            end
                            2'd3: begin
                                out_n       = {in, lane2_q, lane1_q, lane0_q};
                                out_valid_n = 1'b1;
                                slot_n      = 2'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Error flag: sticky latch or single-cycle pulse depending on build.
    always_comb begin
`ifdef TDM_DEMUX_STICKY_ERR_EN
        err_n = err_q | sync_err;
`else
        err_n = sync_err;
`endif
    end

    // Drive ports from registers.
    always_comb begin
        out       = out_q;
        out_valid = out_valid_q;
        slot      = slot_q;
        locked    = (state_q == LOCKED);
        err       = err_q;
    end

endmodule
